multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max cycles waited on mem_ready before bus error (1..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous assert, active-low (0 = reset), released synchronously to clk.
REQ-004 opcode  in  6  instruction[31:26] from datapath IR.
REQ-005 funct  in  6  instruction[5:0] from datapath IR.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory handshake, current access complete this cycle.
REQ-008 pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a  out  1 each  datapath strobes/selects.
REQ-009 reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src  out  2 each  mux selects (reg_dst/mem_to_reg: 0 rt/alu, 1 rd/mem, 2 r31/pc).
REQ-010 instr_done  out  1  one-cycle pulse on instruction retirement.
REQ-011 bus_err, illegal  out  1 each  sticky error flags.
REQ-012 state_o  out  4  current state encoding, debug.
REQ-013 instr_cnt, cycle_cnt  out  32 each  performance counters (see Configuration).

Function
REQ-014 Controller SHALL be a Moore FSM sequencing a shared-memory multicycle datapath; states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, IEXE, IWB, BEQ, JUMP, JAL, JR, ERR.
REQ-015 Supported: R-type (opcode 000000; funct 001000 = jr), lw 100011, sw 101011, beq 000100, addi 001000, slti 001010, j 000010, jal 000011.
REQ-016 FETCH: mem_read=1, iord=0, held until mem_ready; in the mem_ready cycle ir_write=1, pc_en=1, alu_src_b=1 (PC+4), then DECODE.
REQ-017 DECODE: alu_src_b=3 (branch target precompute); next state by opcode; R-type with funct 001000 -> JR; unsupported opcode -> ERR with illegal=1.
REQ-018 lw: MEMADR -> MEMRD (mem_read, iord=1, wait mem_ready) -> MEMWB (reg_write, mem_to_reg=1, reg_dst=0) -> FETCH.
REQ-019 sw: MEMADR -> MEMWR (mem_write, iord=1, wait mem_ready) -> FETCH.
REQ-020 R-type: RTEXE (alu_op=2) -> RTWB (reg_write, reg_dst=1) -> FETCH; addi/slti: IEXE (alu_src_b=2, alu_op=0/3) -> IWB (reg_write, reg_dst=0) -> FETCH.
REQ-021 BEQ: alu_op=1, pc_src=1, pc_en = zero; J: pc_src=2, pc_en=1; JAL: pc_src=2, pc_en=1, reg_write, reg_dst=2, mem_to_reg=2; JR: pc_src=3, pc_en=1; each -> FETCH.
REQ-022 instr_done SHALL pulse in the final state of every instruction (MEMWB, MEMWR-with-ready, RTWB, IWB, BEQ, JUMP, JAL, JR).
REQ-023 Wait counter SHALL clear on entering each memory state, increment per cycle without mem_ready; at count = MEM_TIMEOUT with no mem_ready -> ERR, bus_err=1; mem_ready in that same cycle wins (no error).
REQ-024 ERR SHALL be absorbing until reset; all strobes 0, no memory access.
REQ-025 Strobes not listed for a state SHALL be 0; selects 0.

Reset
REQ-026 rst=0 SHALL force FETCH, wait counter 0, bus_err=illegal=0, counters 0, all strobes 0 within the same cycle (asynchronous).
REQ-027 Reset mid-access SHALL abandon the access; first fetch after release restarts from FETCH.

Configuration
REQ-028 Macro MULTICYCLE_CTRL_PERF_EN: defined -> cycle_cnt increments every non-reset cycle, instr_cnt increments on instr_done, both wrap at 2^32; undefined -> no counter flops, both outputs tied 0.

Structure
REQ-029 Shared package SHALL hold state enum, opcode/funct constants, alu_op and mux-select encodings.
REQ-030 One sub-module, mc_wait_timer (wait counter + timeout compare), SHALL be instantiated; output decode stays in this module.

Verification
REQ-031 addi (0x2008_0005), mem_ready=1 always -> states FETCH,DECODE,IEXE,IWB; reg_write=1 in IWB only; instr_done after 4 cycles.
REQ-032 lw with mem_ready delayed 3 cycles in MEMRD -> stays MEMRD 4 cycles, mem_read/iord held, 1 reg_write, instr_done once.
REQ-033 beq zero=1 then zero=0 -> pc_en=1 with pc_src=1 first, pc_en=0 second; both 3 cycles.
REQ-034 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> ERR after cycle 4, bus_err=1, outputs 0 until rst=0.
REQ-035 opcode 111111 -> ERR with illegal=1; rst pulse low mid-MEMWR -> immediate FETCH, mem_write=0.
REQ-036 With PERF_EN, 10 addi sequence -> instr_cnt=10, cycle_cnt=40; without, both 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// instruction opcode/funct constants, ALU operation codes and datapath mux
// select encodings.
package multicycle_ctrl_pkg;

   // Controller states; the encoding is exported on state_o for debug.
   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_RTEXE  = 4'd6,
      ST_RTWB   = 4'd7,
      ST_IEXE   = 4'd8,
      ST_IWB    = 4'd9,
      ST_BEQ    = 4'd10,
      ST_JUMP   = 4'd11,
      ST_JAL    = 4'd12,
      ST_JR     = 4'd13,
      ST_ERR    = 4'd14
   } state_t;

   // Instruction opcodes (IR[31:26]) and the one funct value of interest.
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // ALU operation requested from the ALU decoder.
   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;
   localparam logic [1:0] ALU_SLT   = 2'd3;

   // Register-file write address select.
   localparam logic [1:0] RD_RT  = 2'd0;
   localparam logic [1:0] RD_RD  = 2'd1;
   localparam logic [1:0] RD_R31 = 2'd2;

   // Register-file write data select.
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   // ALU B operand select.
   localparam logic [1:0] SB_REG    = 2'd0;
   localparam logic [1:0] SB_FOUR   = 2'd1;
   localparam logic [1:0] SB_IMM    = 2'd2;
   localparam logic [1:0] SB_BRANCH = 2'd3;

   // Next-PC source select.
   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_REG    = 2'd3;

   // States that wait on the memory handshake and are guarded by the timer.
   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// mc_wait_timer: counts cycles spent waiting on mem_ready in a memory state
// and flags a timeout once MEM_TIMEOUT waiting cycles would have elapsed.
// The cycle in which mem_ready arrives never times out.
module mc_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic active_i,
   input  logic ready_i,
   output logic timeout_o
);

   // Count value seen during the last permitted waiting cycle.
   localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 32'd1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Next count: restart on every state change, advance on each unanswered cycle.
   always_comb begin
      if (clr_i) begin
         cnt_d = 8'd0;
      end else if (active_i && !ready_i) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = active_i && !ready_i && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore controller for a shared-memory multicycle MIPS-like
// datapath. Optional performance counters are built when the macro
// MULTICYCLE_CTRL_PERF_EN is defined; otherwise instr_cnt/cycle_cnt are 0.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  reg_dst,
   output logic [1:0]  mem_to_reg,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_src,
   output logic        instr_done,
   output logic        bus_err,
   output logic        illegal,
   output logic [3:0]  state_o,
   output logic [31:0] instr_cnt,
   output logic [31:0] cycle_cnt
);

   state_t state_q, state_d;
   logic   bus_err_q, illegal_q;
   logic   set_bus_err_s, set_illegal_s;
   logic   timeout_s, timer_clr_s, timer_active_s;

   assign timer_active_s = is_mem_state(state_q);
   assign timer_clr_s    = (state_d != state_q);

   mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (timer_clr_s),
      .active_i  (timer_active_s),
      .ready_i   (mem_ready),
      .timeout_o (timeout_s)
   );

   // Next-state selection and error-flag set conditions.
   always_comb begin
      state_d       = state_q;
      set_bus_err_s = 1'b0;
      set_illegal_s = 1'b0;
      case (state_q)
         ST_FETCH, ST_MEMRD, ST_MEMWR: begin
            if (mem_ready) begin
               if (state_q == ST_FETCH)      state_d = ST_DECODE;
               else if (state_q == ST_MEMRD) state_d = ST_MEMWB;
               else                          state_d = ST_FETCH;
            end else if (timeout_s) begin
               state_d       = ST_ERR;
               set_bus_err_s = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_JR) state_d = ST_JR;
                  else                state_d = ST_RTEXE;
               end
               OP_LW, OP_SW:     state_d = ST_MEMADR;
               OP_BEQ:           state_d = ST_BEQ;
               OP_ADDI, OP_SLTI: state_d = ST_IEXE;
               OP_J:             state_d = ST_JUMP;
               OP_JAL:           state_d = ST_JAL;
               default: begin
                  state_d       = ST_ERR;
                  set_illegal_s = 1'b1;
               end
            endcase
         end
         ST_MEMADR: begin
            if (opcode == OP_SW) state_d = ST_MEMWR;
            else                 state_d = ST_MEMRD;
         end
         ST_RTEXE: state_d = ST_RTWB;
         ST_IEXE:  state_d = ST_IWB;
         ST_MEMWB, ST_RTWB, ST_IWB, ST_BEQ, ST_JUMP, ST_JAL, ST_JR: state_d = ST_FETCH;
         ST_ERR:   state_d = ST_ERR;
         default:  state_d = ST_ERR;
      endcase
   end

   // State register with sticky error flags; only reset clears them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_FETCH;
         bus_err_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bus_err_q <= bus_err_q | set_bus_err_s;
         illegal_q <= illegal_q | set_illegal_s;
      end
   end

   // Datapath strobes and selects per state; held at zero while rst is low.
   always_comb begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      reg_dst    = RD_RT;
      mem_to_reg = WB_ALU;
      alu_src_b  = SB_REG;
      alu_op     = ALU_ADD;
      pc_src     = PC_ALU;
      instr_done = 1'b0;
      if (rst) begin
         case (state_q)
            ST_FETCH: begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write  = 1'b1;
                  pc_en     = 1'b1;
                  alu_src_b = SB_FOUR;
               end else begin
                  ir_write = 1'b0;
               end
            end
            ST_DECODE: alu_src_b = SB_BRANCH;
            ST_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = SB_IMM;
            end
            ST_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            ST_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = WB_MEM;
               reg_dst    = RD_RT;
               instr_done = 1'b1;
            end
            ST_MEMWR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
               if (mem_ready) instr_done = 1'b1;
               else           instr_done = 1'b0;
            end
            ST_RTEXE: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_FUNCT;
            end
            ST_RTWB: begin
               reg_write  = 1'b1;
               reg_dst    = RD_RD;
               instr_done = 1'b1;
            end
            ST_IEXE: begin
               alu_src_a = 1'b1;
               alu_src_b = SB_IMM;
               if (opcode == OP_SLTI) alu_op = ALU_SLT;
               else                   alu_op = ALU_ADD;
            end
            ST_IWB: begin
               reg_write  = 1'b1;
               reg_dst    = RD_RT;
               instr_done = 1'b1;
            end
            ST_BEQ: begin
               alu_src_a  = 1'b1;
               alu_op     = ALU_SUB;
               pc_src     = PC_ALUOUT;
               pc_en      = zero;
               instr_done = 1'b1;
            end
            ST_JUMP: begin
               pc_src     = PC_JUMP;
               pc_en      = 1'b1;
               instr_done = 1'b1;
            end
            ST_JAL: begin
               pc_src     = PC_JUMP;
               pc_en      = 1'b1;
               reg_write  = 1'b1;
               reg_dst    = RD_R31;
               mem_to_reg = WB_PC;
               instr_done = 1'b1;
            end
            ST_JR: begin
               pc_src     = PC_REG;
               pc_en      = 1'b1;
               instr_done = 1'b1;
            end
            default: begin
            end
         endcase
      end else begin
         instr_done = 1'b0;
      end
   end

   assign bus_err = bus_err_q;
   assign illegal = illegal_q;
   assign state_o = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] instr_cnt_q, cycle_cnt_q;

   // Free-running cycle counter and retired-instruction counter, both wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_cnt_q <= 32'd0;
         cycle_cnt_q <= 32'd0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
         else            instr_cnt_q <= instr_cnt_q;
      end
   end

   assign instr_cnt = instr_cnt_q;
   assign cycle_cnt = cycle_cnt_q;
`else
   assign instr_cnt = 32'd0;
   assign cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each instruction is expanded into
// the per-cycle outputs its instruction class must produce, then replayed
// cycle by cycle against the DUT.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  opcode = 6'd0;
   logic [5:0]  funct = 6'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
   logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
   logic        instr_done, bus_err, illegal;
   logic [3:0]  state_o;
   logic [31:0] instr_cnt, cycle_cnt;

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .instr_done(instr_done), .bus_err(bus_err), .illegal(illegal),
      .state_o(state_o), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
      logic [1:0] reg_dst, mem_to_reg, alu_op, pc_src;
      logic       done, bus_err, illegal;
   } vec_t;

   vec_t exp_q[$];
   logic rdy_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t blank(input state_t s);
      vec_t v;
      v = '0;
      v.st = s;
      return v;
   endfunction

   function automatic vec_t observe();
      vec_t v;
      v.st = state_o; v.pc_en = pc_en; v.iord = iord; v.mem_read = mem_read;
      v.mem_write = mem_write; v.ir_write = ir_write; v.reg_write = reg_write;
      v.reg_dst = reg_dst; v.mem_to_reg = mem_to_reg; v.alu_op = alu_op;
      v.pc_src = pc_src; v.done = instr_done; v.bus_err = bus_err; v.illegal = illegal;
      return v;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J, OP_JAL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [5:0] pick_op(input int i);
      case (i)
         0: return OP_RTYPE;  1: return OP_LW;   2: return OP_SW;   3: return OP_BEQ;
         4: return OP_ADDI;   5: return OP_SLTI; 6: return OP_J;    default: return OP_JAL;
      endcase
   endfunction

   task automatic push(input vec_t v, input logic r);
      exp_q.push_back(v);
      rdy_q.push_back(r);
   endtask

   // Expected cycles for one instruction: fw fetch waits, mw memory waits.
   task automatic build_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int fw, input int mw);
      vec_t v;
      for (int i = 0; i < fw; i++) begin
         v = blank(ST_FETCH); v.mem_read = 1'b1; push(v, 1'b0);
      end
      v = blank(ST_FETCH); v.mem_read = 1'b1; v.ir_write = 1'b1; v.pc_en = 1'b1; push(v, 1'b1);
      push(blank(ST_DECODE), rb());
      case (op)
         OP_RTYPE: begin
            if (fn == FN_JR) begin
               v = blank(ST_JR); v.pc_src = 2'd3; v.pc_en = 1'b1; v.done = 1'b1; push(v, rb());
            end else begin
               v = blank(ST_RTEXE); v.alu_op = 2'd2; push(v, rb());
               v = blank(ST_RTWB); v.reg_write = 1'b1; v.reg_dst = 2'd1; v.done = 1'b1; push(v, rb());
            end
         end
         OP_LW: begin
            push(blank(ST_MEMADR), rb());
            for (int i = 0; i < mw; i++) begin
               v = blank(ST_MEMRD); v.mem_read = 1'b1; v.iord = 1'b1; push(v, 1'b0);
            end
            v = blank(ST_MEMRD); v.mem_read = 1'b1; v.iord = 1'b1; push(v, 1'b1);
            v = blank(ST_MEMWB); v.reg_write = 1'b1; v.mem_to_reg = 2'd1; v.done = 1'b1; push(v, rb());
         end
         OP_SW: begin
            push(blank(ST_MEMADR), rb());
            for (int i = 0; i < mw; i++) begin
               v = blank(ST_MEMWR); v.mem_write = 1'b1; v.iord = 1'b1; push(v, 1'b0);
            end
            v = blank(ST_MEMWR); v.mem_write = 1'b1; v.iord = 1'b1; v.done = 1'b1; push(v, 1'b1);
         end
         OP_BEQ: begin
            v = blank(ST_BEQ); v.alu_op = 2'd1; v.pc_src = 2'd1; v.pc_en = z; v.done = 1'b1; push(v, rb());
         end
         OP_ADDI, OP_SLTI: begin
            v = blank(ST_IEXE); v.alu_op = (op == OP_SLTI) ? 2'd3 : 2'd0; push(v, rb());
            v = blank(ST_IWB); v.reg_write = 1'b1; v.done = 1'b1; push(v, rb());
         end
         OP_J: begin
            v = blank(ST_JUMP); v.pc_src = 2'd2; v.pc_en = 1'b1; v.done = 1'b1; push(v, rb());
         end
         OP_JAL: begin
            v = blank(ST_JAL); v.pc_src = 2'd2; v.pc_en = 1'b1; v.reg_write = 1'b1;
            v.reg_dst = 2'd2; v.mem_to_reg = 2'd2; v.done = 1'b1; push(v, rb());
         end
         default: begin
            for (int i = 0; i < 3; i++) begin
               v = blank(ST_ERR); v.illegal = 1'b1; push(v, rb());
            end
         end
      endcase
   endtask

   // Replays up to limit queued cycles; enters and leaves just after a negedge.
   task automatic run_queue(input string name, input int limit);
      int n;
      vec_t e, obs;
      logic r;
      n = 0;
      while (exp_q.size() > 0 && n < limit) begin
         e = exp_q.pop_front();
         r = rdy_q.pop_front();
         mem_ready = r;
         #1;
         obs = observe();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, n, obs, e);
         end
         n++;
         @(negedge clk);
      end
      exp_q.delete();
      rdy_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (observe() !== blank(ST_FETCH)) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h", observe(), blank(ST_FETCH));
      end
      checks++;
      if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d expected 0/0", instr_cnt, cycle_cnt);
      end
   endtask

   task automatic test_addi();
      logic [5:0] srcb [3];
      do_reset();
      opcode = OP_ADDI; funct = 6'h05;
      build_instr(OP_ADDI, 6'h05, 1'b0, 0, 0);
      run_queue("addi", 100);
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1;
         #1;
         srcb[i] = {4'd0, alu_src_b};
         @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (srcb[0] !== 6'd1 || srcb[1] !== 6'd3 || srcb[2] !== 6'd2) begin
         errors++;
         $display("FAIL addi_alu_src_b: got %0d,%0d,%0d expected 1,3,2", srcb[0], srcb[1], srcb[2]);
      end
   endtask

   task automatic test_lw_wait();
      do_reset();
      opcode = OP_LW; funct = 6'($urandom);
      build_instr(OP_LW, funct, 1'b0, 0, 3);
      run_queue("lw_wait3", 100);
   endtask

   task automatic test_beq();
      do_reset();
      opcode = OP_BEQ;
      zero = 1'b1;
      build_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
      run_queue("beq_taken", 100);
      zero = 1'b0;
      build_instr(OP_BEQ, 6'd0, 1'b0, 0, 0);
      run_queue("beq_not_taken", 100);
   endtask

   task automatic test_timeout();
      vec_t v;
      do_reset();
      opcode = OP_ADDI;
      build_instr(OP_ADDI, 6'd0, 1'b0, int'(TO) - 1, 0);
      run_queue("ready_on_last_wait", 100);
      for (int i = 0; i < int'(TO); i++) begin
         v = blank(ST_FETCH); v.mem_read = 1'b1; push(v, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         v = blank(ST_ERR); v.bus_err = 1'b1; push(v, rb());
      end
      run_queue("fetch_timeout", 100);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (state_o !== 4'(ST_FETCH) || bus_err !== 1'b0 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL err_reset: got st=%0d bus_err=%b mem_read=%b expected 0,0,0",
                  state_o, bus_err, mem_read);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_illegal();
      logic [5:0] op;
      do_reset();
      op = 6'b111111;
      opcode = op;
      build_instr(op, 6'd0, 1'b0, 0, 0);
      run_queue("illegal_3f", 100);
      do_reset();
      op = 6'($urandom);
      while (supported(op)) op = 6'($urandom);
      opcode = op;
      build_instr(op, 6'd0, 1'b0, 1, 0);
      run_queue("illegal_rand", 100);
   endtask

   task automatic test_reset_mid_memwr();
      do_reset();
      opcode = OP_SW;
      build_instr(OP_SW, 6'd0, 1'b0, 0, 3);
      run_queue("sw_before_abort", 5);
      mem_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (state_o !== 4'(ST_FETCH) || mem_write !== 1'b0 || iord !== 1'b0) begin
         errors++;
         $display("FAIL memwr_abort: got st=%0d mem_write=%b iord=%b expected 0,0,0",
                  state_o, mem_write, iord);
      end
      @(negedge clk);
      rst = 1'b1;
      opcode = OP_ADDI;
      build_instr(OP_ADDI, 6'd0, 1'b0, 0, 0);
      run_queue("after_abort", 100);
   endtask

   task automatic test_random();
      logic [5:0] op, fn;
      logic       z;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         op = pick_op(int'($urandom_range(0, 7)));
         fn = ($urandom_range(0, 3) == 0) ? FN_JR : 6'($urandom);
         z  = rb();
         opcode = op; funct = fn; zero = z;
         build_instr(op, fn, z, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)));
         run_queue("random", 100);
      end
   endtask

   task automatic test_perf();
      logic [31:0] exp_i, exp_c;
      do_reset();
      opcode = OP_ADDI;
      for (int k = 0; k < 10; k++) begin
         build_instr(OP_ADDI, 6'd0, 1'b0, 0, 0);
         run_queue("perf_addi", 100);
      end
`ifdef MULTICYCLE_CTRL_PERF_EN
      exp_i = 32'd10; exp_c = 32'd40;
`else
      exp_i = 32'd0;  exp_c = 32'd0;
`endif
      #1;
      checks++;
      if (instr_cnt !== exp_i || cycle_cnt !== exp_c) begin
         errors++;
         $display("FAIL perf_counters: got %0d/%0d expected %0d/%0d",
                  instr_cnt, cycle_cnt, exp_i, exp_c);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_lw_wait();
      test_beq();
      test_timeout();
      test_illegal();
      test_reset_mid_memwr();
      test_random();
      test_perf();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
